// File: rtl/round_robin_arbiter_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [1:0]       arb_idx_t;

    // One-hot encode a requester index into a grant vector.
    function automatic req_vec_t idx_to_onehot(input arb_idx_t idx);
        req_vec_t v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between request sources and the arbiter.
interface arb_if;
    import arb_pkg::*;

    req_vec_t req;
    req_vec_t gnt;

    // Request sources drive req and observe gnt.
    modport master (output req, input gnt);
    // The arbiter observes req and drives gnt.
    modport slave  (input req, output gnt);
endinterface

// File: rtl/round_robin_arbiter_rr_pick.sv
// Combinational rotating-priority picker: rotate by ptr, take the lowest
// asserted rotated bit, rotate the winner index back.
module rr_pick
    import arb_pkg::*;
(
    input  req_vec_t req,
    input  arb_idx_t ptr,
    output arb_idx_t winner,
    output logic     valid
);

    req_vec_t rot;
    arb_idx_t off;

    // Rotate the request vector so that requester ptr lands in bit 0.
    always_comb begin
        rot = '0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            arb_idx_t src;
            src    = arb_idx_t'(j) + ptr;
            rot[j] = req[src];
        end
    end

    // Fixed-priority pick on the rotated vector; scanning downward lets the
    // lowest asserted bit overwrite any higher one.
    always_comb begin
        valid = 1'b0;
        off   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            int unsigned j;
            j = N_REQ - 1 - k;
            if (rot[j]) begin
                valid = 1'b1;
                off   = arb_idx_t'(j);
            end
        end
        winner = off + ptr;
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Four-requester round-robin arbiter with registered grants.
module round_robin_arbiter
    import arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req3,
    input  logic req2,
    input  logic req1,
    input  logic req0,
    output logic gnt3,
    output logic gnt2,
    output logic gnt1,
    output logic gnt0
);

    req_vec_t req_vec;
    req_vec_t gnt_d, gnt_q;
    arb_idx_t ptr_d, ptr_q;
    arb_idx_t win_idx;
    logic     win_valid;

    assign req_vec = {req3, req2, req1, req0};

    rr_pick u_pick (
        .req    (req_vec),
        .ptr    (ptr_q),
        .winner (win_idx),
        .valid  (win_valid)
    );

    // Next grant and pointer: winner gets the grant, priority moves past it;
    // with no requests the grant clears and the pointer holds.
    always_comb begin
        gnt_d = '0;
        ptr_d = ptr_q;
        if (win_valid) begin
            gnt_d = idx_to_onehot(win_idx);
            ptr_d = win_idx + 2'd1;
        end
    end

    // Grant and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q <= '0;
            ptr_q <= '0;
        end else begin
            gnt_q <= gnt_d;
            ptr_q <= ptr_d;
        end
    end

    assign {gnt3, gnt2, gnt1, gnt0} = gnt_q;

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Self-checking bench for round_robin_arbiter: reference model pushes the
// expected grant per driven cycle, popped and compared after the clock edge.
module tb_round_robin_arbiter;
    import arb_pkg::*;

    logic clk;
    logic rst;
    logic gnt3, gnt2, gnt1, gnt0;

    arb_if bus ();

    assign bus.gnt = {gnt3, gnt2, gnt1, gnt0};

    round_robin_arbiter dut (
        .clk  (clk),
        .rst  (rst),
        .req3 (bus.req[3]),
        .req2 (bus.req[2]),
        .req1 (bus.req[1]),
        .req0 (bus.req[0]),
        .gnt3 (gnt3),
        .gnt2 (gnt2),
        .gnt1 (gnt1),
        .gnt0 (gnt0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [3:0] exp_gnt_q[$];
    logic [1:0] exp_ptr_q[$];
    logic [1:0] m_ptr = 2'd0;

    // Count a comparison and report it on mismatch.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model step: returns the grant the arbiter should register.
    function automatic logic [3:0] model_step(input logic r, input logic [3:0] rq);
        logic [3:0] g;
        logic       found;
        g     = 4'b0000;
        found = 1'b0;
        if (r) begin
            m_ptr = 2'd0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (int'(m_ptr) + k) % 4;
                if (!found && rq[idx]) begin
                    found  = 1'b1;
                    g[idx] = 1'b1;
                    m_ptr  = 2'((idx + 1) % 4);
                end
            end
        end
        return g;
    endfunction

    // Drive one cycle, score it against the model, return the observed grant.
    task automatic run_cycle(input logic r, input logic [3:0] rq, output logic [3:0] g_obs);
        logic [3:0] eg;
        logic [1:0] ep;
        rst     = r;
        bus.req = rq;
        exp_gnt_q.push_back(model_step(r, rq));
        exp_ptr_q.push_back(m_ptr);
        @(posedge clk);
        #1;
        g_obs = bus.gnt;
        eg = exp_gnt_q.pop_front();
        ep = exp_ptr_q.pop_front();
        check_eq("sb_gnt", 32'(g_obs), 32'(eg));
        check_eq("sb_ptr", 32'(dut.ptr_q), 32'(ep));
        check_eq("onehot0", 32'($onehot0(g_obs)), 32'd1);
    endtask

    logic [3:0] g;
    logic [3:0] rot_req [5];
    logic [3:0] rot_exp [5];
    int unsigned cnt [4];

    initial begin
        rst     = 1'b1;
        bus.req = 4'b0000;

        // 1. Reset held 5 cycles with arbitrary requests, then idle.
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b1, 4'($urandom_range(0, 15)), g);
            check_eq("t1_rst_gnt", 32'(g), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 4'b0000, g);
            check_eq("t1_idle_gnt", 32'(g), 32'd0);
        end

        // 2. Single one-cycle request from requester 0.
        run_cycle(1'b0, 4'b0001, g);
        check_eq("t2_gnt0", 32'(g), 32'b0001);
        run_cycle(1'b0, 4'b0000, g);
        check_eq("t2_drop", 32'(g), 32'd0);
        check_eq("t2_ptr", 32'(dut.ptr_q), 32'd1);

        // 3. Rotation sequence from ptr=1.
        rot_req[0] = 4'b0011; rot_exp[0] = 4'b0010;
        rot_req[1] = 4'b0101; rot_exp[1] = 4'b0100;
        rot_req[2] = 4'b1001; rot_exp[2] = 4'b1000;
        rot_req[3] = 4'b0001; rot_exp[3] = 4'b0001;
        rot_req[4] = 4'b0000; rot_exp[4] = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            run_cycle(1'b0, rot_req[i], g);
            check_eq("t3_rot", 32'(g), 32'(rot_exp[i]));
        end

        // 4. Fairness: reset to ptr=0, all four requesting for 8 cycles.
        run_cycle(1'b1, 4'b0000, g);
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] want;
            want = 4'b0001 << (i % 4);
            run_cycle(1'b0, 4'b1111, g);
            check_eq("t4_order", 32'(g), 32'(want));
            for (int j = 0; j < 4; j++) if (g[j]) cnt[j]++;
        end
        for (int j = 0; j < 4; j++) check_eq("t4_count", cnt[j], 32'd2);
        run_cycle(1'b0, 4'b0000, g);

        // 5. Sole persistent requester 2 keeps the grant.
        for (int i = 0; i < 4; i++) begin
            run_cycle(1'b0, 4'b0100, g);
            check_eq("t5_sole", 32'(g), 32'b0100);
        end
        run_cycle(1'b0, 4'b0000, g);
        check_eq("t5_drop", 32'(g), 32'd0);

        // 6. Mid-operation reset with all requests held.
        run_cycle(1'b0, 4'b1111, g);
        check_eq("t6_pre_a", 32'(g), 32'b1000);
        run_cycle(1'b0, 4'b1111, g);
        check_eq("t6_pre_b", 32'(g), 32'b0001);
        run_cycle(1'b1, 4'b1111, g);
        check_eq("t6_rst", 32'(g), 32'd0);
        run_cycle(1'b0, 4'b1111, g);
        check_eq("t6_after", 32'(g), 32'b0001);
        run_cycle(1'b0, 4'b0000, g);

        // Short random soak checked purely by the scoreboard.
        for (int i = 0; i < 40; i++) begin
            run_cycle(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)), g);
        end

        check_eq("sb_empty", exp_gnt_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
